// File: rtl/lea_split_from128_tx.sv
// lea_split_from128_tx: captures one 8*NBYTES-bit block and emits it one byte per handshake.
module lea_split_from128_tx #(
  parameter int NBYTES = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [8*NBYTES-1:0]   Din,
  input  logic                  Din_valid,
  output logic                  Din_ready,
  output logic [7:0]            Dout,
  output logic                  Dout_valid,
  input  logic                  Dout_ready,
  output logic                  Dout_last,
  output logic [3:0]            Dout_idx
);
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n, sel;
  logic [8*NBYTES-1:0] buffer, buffer_n;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      count  <= '0;
      buffer <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      buffer <= buffer_n;
    end
  end
  // Dout is selected only from registered buffer/count, so Din never reaches it combinationally.
  always_comb begin
    state_n    = state;
    count_n    = count;
    buffer_n   = buffer;
    Dout_valid = state == SEND;
    Dout_last  = Dout_valid && count == LAST;
    Din_ready  = state == IDLE || (Dout_last && Dout_ready);
    sel        = MSB_FIRST ? LAST - count : count;
    Dout       = Dout_valid ? buffer[8*int'(sel) +: 8] : 8'd0;
    Dout_idx   = 4'(count);
    if (Din_ready && Din_valid) begin
      buffer_n = Din;
      count_n  = '0;
      state_n  = SEND;
    end else if (Dout_valid && Dout_ready) begin
      if (Dout_last) state_n = IDLE;
      else count_n = count + 1'b1;
    end
  end
endmodule

// File: tb/tb_lea_split_from128_tx.sv
// tb_lea_split_from128_tx: checks LSB-first and MSB-first instances against a byte-level model.
module tb_lea_split_from128_tx;
  logic CLK = 1'b0, RST = 1'b1;
  logic [127:0] Din = '0;
  logic Din_valid = 1'b0, Dout_ready = 1'b0;
  logic Din_ready, Dout_valid, Dout_last, Din_ready_m, Dout_valid_m, Dout_last_m;
  logic [7:0] Dout, Dout_m;
  logic [3:0] Dout_idx, Dout_idx_m;
  int n_assert = 0, n_fail = 0;
  bit busy = 0;
  int pos = 0;
  logic [127:0] blk = '0;
  logic [127:0] p0 = 128'h0F0E0D0C0B0A09080706050403020100;
  lea_split_from128_tx #(.NBYTES(16), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .Din(Din), .Din_valid(Din_valid), .Din_ready(Din_ready),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready),
    .Dout_last(Dout_last), .Dout_idx(Dout_idx));
  lea_split_from128_tx #(.NBYTES(16), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .Din(Din), .Din_valid(Din_valid), .Din_ready(Din_ready_m),
    .Dout(Dout_m), .Dout_valid(Dout_valid_m), .Dout_ready(Dout_ready),
    .Dout_last(Dout_last_m), .Dout_idx(Dout_idx_m));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic [127:0] d, input logic dv, input logic dr, input logic r);
    logic last, rdy;
    logic [7:0] lsb, msb;
    @(negedge CLK);
    Din = d; Din_valid = dv; Dout_ready = dr; RST = r;
    #1;
    last = busy && pos == 15;
    rdy  = !busy || (last && dr);
    lsb  = busy ? blk[8*pos +: 8] : 8'd0;
    msb  = busy ? blk[8*(15-pos) +: 8] : 8'd0;
    if (!r) begin
      chk("valid", {7'd0, Dout_valid}, {7'd0, busy});
      chk("dout", Dout, lsb);
      chk("last", {7'd0, Dout_last}, {7'd0, last});
      chk("idx", {4'd0, Dout_idx}, 8'(pos));
      chk("din_ready", {7'd0, Din_ready}, {7'd0, rdy});
      chk("m_valid", {7'd0, Dout_valid_m}, {7'd0, busy});
      chk("m_dout", Dout_m, msb);
      chk("m_last", {7'd0, Dout_last_m}, {7'd0, last});
      chk("m_idx", {4'd0, Dout_idx_m}, 8'(pos));
      chk("m_din_ready", {7'd0, Din_ready_m}, {7'd0, rdy});
    end
    if (r) begin
      busy = 0; pos = 0;
    end else if (rdy && dv) begin
      busy = 1; pos = 0; blk = d;
    end else if (busy && dr) begin
      if (last) busy = 0;
      else pos++;
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    step('0, 0, 1, 1);
    step('0, 0, 1, 1);
    step('0, 0, 1, 0);
    step(p0, 1, 1, 0);
    for (int i = 0; i < 18; i++) step('0, 0, 1, 0);
    step(p0, 1, 0, 0);
    for (int i = 0; i < 60; i++) step(rnd128(), 0, 1'($urandom), 0);
    step({16{8'hAA}}, 1, 1, 0);
    for (int i = 0; i < 16; i++) step({16{8'h55}}, 1, 1, 0);
    for (int i = 0; i < 18; i++) step(rnd128(), 0, 1, 0);
    step(rnd128(), 1, 1, 0);
    for (int i = 0; i < 6; i++) step('0, 0, 1, 0);
    step('0, 0, 1, 1);
    step('0, 0, 0, 0);
    step(p0, 1, 1, 0);
    for (int i = 0; i < 18; i++) step('0, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      step(rnd128(), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 60) == 0));
    step('0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
